// File: rtl/alu_exec_unit.sv
// alu_exec_unit: EX-stage ALU with integrated operation decode.
// Decodes alu_op/funct3/funct7 into a 4-bit operation code and executes it.
// Base ops finish in one cycle. MUL/DIV/DIVU/REM/REMU use an iterative
// one-bit-per-cycle datapath. Handshakes are valid/ready on both sides.
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | waiting for a request, in_ready=1
// BUSY  | iterating shift-add multiply or restoring divide
// DONE  | result held, out_valid=1 until out_ready

module alu_exec_unit #(
    parameter  int XLEN = 32,
    localparam int SHW  = $clog2(XLEN)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [1:0]      alu_op,
    input  logic [6:0]      funct7,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] op_a,
    input  logic [XLEN-1:0] op_b,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] result,
    output logic [3:0]      operation,
    output logic            illegal,
    output logic            busy
);

    localparam logic [3:0] OP_AND     = 4'b0000;
    localparam logic [3:0] OP_OR      = 4'b0001;
    localparam logic [3:0] OP_ADD     = 4'b0010;
    localparam logic [3:0] OP_SLL     = 4'b0011;
    localparam logic [3:0] OP_SRL     = 4'b0100;
    localparam logic [3:0] OP_SRA     = 4'b0101;
    localparam logic [3:0] OP_SUB     = 4'b0110;
    localparam logic [3:0] OP_SLT     = 4'b0111;
    localparam logic [3:0] OP_SLTU    = 4'b1000;
    localparam logic [3:0] OP_MUL     = 4'b1001;
    localparam logic [3:0] OP_DIV     = 4'b1010;
    localparam logic [3:0] OP_DIVU    = 4'b1011;
    localparam logic [3:0] OP_XOR     = 4'b1100;
    localparam logic [3:0] OP_REM     = 4'b1101;
    localparam logic [3:0] OP_REMU    = 4'b1110;
    localparam logic [3:0] OP_ILLEGAL = 4'b1111;

    localparam logic [SHW:0]    CNT_INIT = (SHW+1)'(XLEN);
    localparam logic [SHW:0]    CNT_ONE  = (SHW+1)'(1);
    localparam logic [XLEN-1:0] INT_MIN  = {1'b1, {(XLEN-1){1'b0}}};

    typedef enum logic [1:0] {
        S_IDLE,
        S_BUSY,
        S_DONE
    } state_t;

    state_t          state_q, state_d;
    logic [SHW:0]    cnt_q, cnt_d;
    logic [XLEN-1:0] acc_q, acc_d;
    logic [XLEN-1:0] opx_q, opx_d;
    logic [XLEN-1:0] opy_q, opy_d;
    logic            qneg_q, qneg_d;
    logic            rneg_q, rneg_d;
    logic [XLEN-1:0] result_q, result_d;
    logic [3:0]      operation_q, operation_d;
    logic            illegal_q, illegal_d;

    logic [3:0]      op_dec;
    logic [XLEN-1:0] alu_res;
    logic [SHW-1:0]  shamt;
    logic            signed_div;
    logic            div_ovf;
    logic [XLEN-1:0] mag_a;
    logic [XLEN-1:0] mag_b;
    logic [XLEN:0]   rem_sh;
    logic [XLEN:0]   rem_diff;

    assign shamt = op_b[SHW-1:0];

    // Decode the control fields into an operation code.
    always_comb begin
        op_dec = OP_ILLEGAL;
        case (alu_op)
            2'b00: op_dec = OP_ADD;
            2'b01: op_dec = OP_SUB;
            default: begin
                if (alu_op == 2'b10 && funct7 == 7'b0000001) begin
                    case (funct3)
                        3'b000:  op_dec = OP_MUL;
                        3'b100:  op_dec = OP_DIV;
                        3'b101:  op_dec = OP_DIVU;
                        3'b110:  op_dec = OP_REM;
                        3'b111:  op_dec = OP_REMU;
                        default: op_dec = OP_ILLEGAL;
                    endcase
                end else if (alu_op == 2'b10 && funct7 != 7'b0000000
                             && funct7 != 7'b0100000) begin
                    op_dec = OP_ILLEGAL;
                end else begin
                    case (funct3)
                        3'b000:  op_dec = (alu_op == 2'b10 && funct7 == 7'b0100000)
                                          ? OP_SUB : OP_ADD;
                        3'b001:  op_dec = OP_SLL;
                        3'b010:  op_dec = OP_SLT;
                        3'b011:  op_dec = OP_SLTU;
                        3'b100:  op_dec = OP_XOR;
                        3'b101:  op_dec = funct7[5] ? OP_SRA : OP_SRL;
                        3'b110:  op_dec = OP_OR;
                        default: op_dec = OP_AND;
                    endcase
                end
            end
        endcase
    end

    // Single-cycle results; iterative ops and ILLEGAL fall through to zero.
    always_comb begin
        alu_res = '0;
        case (op_dec)
            OP_AND:  alu_res = op_a & op_b;
            OP_OR:   alu_res = op_a | op_b;
            OP_XOR:  alu_res = op_a ^ op_b;
            OP_ADD:  alu_res = op_a + op_b;
            OP_SUB:  alu_res = op_a - op_b;
            OP_SLL:  alu_res = op_a << shamt;
            OP_SRL:  alu_res = op_a >> shamt;
            OP_SRA:  alu_res = $unsigned($signed(op_a) >>> shamt);
            OP_SLT:  alu_res = {{(XLEN-1){1'b0}}, ($signed(op_a) < $signed(op_b))};
            OP_SLTU: alu_res = {{(XLEN-1){1'b0}}, (op_a < op_b)};
            default: alu_res = '0;
        endcase
    end

    // Operand magnitudes and special-case detection for division.
    always_comb begin
        signed_div = (op_dec == OP_DIV) || (op_dec == OP_REM);
        div_ovf    = signed_div && (op_a == INT_MIN) && (op_b == '1);
        mag_a      = (signed_div && op_a[XLEN-1]) ? (-op_a) : op_a;
        mag_b      = (signed_div && op_b[XLEN-1]) ? (-op_b) : op_b;
    end

    // Next-state logic: request capture, one iteration step, and result hand-off.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        acc_d       = acc_q;
        opx_d       = opx_q;
        opy_d       = opy_q;
        qneg_d      = qneg_q;
        rneg_d      = rneg_q;
        result_d    = result_q;
        operation_d = operation_q;
        illegal_d   = illegal_q;
        rem_sh      = '0;
        rem_diff    = '0;

        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    operation_d = op_dec;
                    illegal_d   = (op_dec == OP_ILLEGAL);
                    result_d    = alu_res;
                    state_d     = S_DONE;
                    case (op_dec)
                        OP_MUL: begin
                            state_d = S_BUSY;
                            cnt_d   = CNT_INIT;
                            acc_d   = '0;
                            opx_d   = op_a;
                            opy_d   = op_b;
                        end
                        OP_DIV, OP_DIVU, OP_REM, OP_REMU: begin
                            if (op_b == '0) begin
                                result_d = (op_dec == OP_DIV || op_dec == OP_DIVU)
                                           ? '1 : op_a;
                            end else if (div_ovf) begin
                                result_d = (op_dec == OP_DIV) ? op_a : '0;
                            end else begin
                                state_d = S_BUSY;
                                cnt_d   = CNT_INIT;
                                acc_d   = '0;
                                opx_d   = mag_a;
                                opy_d   = mag_b;
                                qneg_d  = signed_div && (op_a[XLEN-1] ^ op_b[XLEN-1]);
                                rneg_d  = signed_div && op_a[XLEN-1];
                            end
                        end
                        default: ;
                    endcase
                end
            end

            S_BUSY: begin
                cnt_d = cnt_q - CNT_ONE;
                if (operation_q == OP_MUL) begin
                    // acc accumulates the product, opy is the shifted multiplicand
                    if (opx_q[0]) begin
                        acc_d = acc_q + opy_q;
                    end
                    opy_d = opy_q << 1;
                    opx_d = opx_q >> 1;
                end else begin
                    // acc is the partial remainder, opx shifts dividend out and quotient in
                    rem_sh   = {acc_q, opx_q[XLEN-1]};
                    rem_diff = rem_sh - {1'b0, opy_q};
                    if (!rem_diff[XLEN]) begin
                        acc_d = rem_diff[XLEN-1:0];
                        opx_d = {opx_q[XLEN-2:0], 1'b1};
                    end else begin
                        acc_d = rem_sh[XLEN-1:0];
                        opx_d = {opx_q[XLEN-2:0], 1'b0};
                    end
                end
                if (cnt_q == CNT_ONE) begin
                    state_d = S_DONE;
                    case (operation_q)
                        OP_MUL:  result_d = acc_d;
                        OP_DIV:  result_d = qneg_q ? (-opx_d) : opx_d;
                        OP_DIVU: result_d = opx_d;
                        OP_REM:  result_d = rneg_q ? (-acc_d) : acc_d;
                        default: result_d = acc_d;
                    endcase
                end
            end

            S_DONE: begin
                if (out_ready) begin
                    state_d = S_IDLE;
                end
            end

            default: state_d = S_IDLE;
        endcase
    end

    // State and datapath registers; reset discards any in-flight operation.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            acc_q       <= '0;
            opx_q       <= '0;
            opy_q       <= '0;
            qneg_q      <= 1'b0;
            rneg_q      <= 1'b0;
            result_q    <= '0;
            operation_q <= 4'b0000;
            illegal_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            acc_q       <= acc_d;
            opx_q       <= opx_d;
            opy_q       <= opy_d;
            qneg_q      <= qneg_d;
            rneg_q      <= rneg_d;
            result_q    <= result_d;
            operation_q <= operation_d;
            illegal_q   <= illegal_d;
        end
    end

    assign in_ready  = (state_q == S_IDLE) && !rst;
    assign out_valid = (state_q == S_DONE);
    assign busy      = (state_q == S_BUSY);
    assign result    = result_q;
    assign operation = operation_q;
    assign illegal   = illegal_q;

endmodule

// File: tb/tb_alu_exec_unit.sv
// Directed bench for alu_exec_unit with hand-computed expected values.
module tb_alu_exec_unit;

    localparam int XLEN = 32;

    logic            clk;
    logic            rst;
    logic            in_valid;
    logic            in_ready;
    logic [1:0]      alu_op;
    logic [6:0]      funct7;
    logic [2:0]      funct3;
    logic [XLEN-1:0] op_a;
    logic [XLEN-1:0] op_b;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] result;
    logic [3:0]      operation;
    logic            illegal;
    logic            busy;

    int total_cnt;
    int pass_cnt;
    int lat;
    int busy_cycles;

    alu_exec_unit #(.XLEN(XLEN)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .alu_op    (alu_op),
        .funct7    (funct7),
        .funct3    (funct3),
        .op_a      (op_a),
        .op_b      (op_b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .operation (operation),
        .illegal   (illegal),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total_cnt++;
        assert (obs === exp) pass_cnt++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    // Present a request for one accept edge, then sample until out_valid.
    task automatic issue(input logic [1:0] aop, input logic [6:0] f7, input logic [2:0] f3,
                         input logic [XLEN-1:0] a, input logic [XLEN-1:0] b);
        @(negedge clk);
        alu_op   = aop;
        funct7   = f7;
        funct3   = f3;
        op_a     = a;
        op_b     = b;
        in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        op_a     = '0;
        op_b     = '0;
        lat         = 1;
        busy_cycles = 0;
        while (!out_valid && lat < 200) begin
            if (busy) busy_cycles++;
            @(negedge clk);
            lat++;
        end
        if (!out_valid) check("out_valid_timeout", {63'd0, out_valid}, 64'd1);
    endtask

    task automatic retire();
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    task automatic expect_out(input string tag, input logic [XLEN-1:0] res,
                              input logic [3:0] op, input logic ill, input int exp_lat);
        check({tag, "_result"}, 64'(result), 64'(res));
        check({tag, "_operation"}, 64'(operation), 64'(op));
        check({tag, "_illegal"}, 64'(illegal), 64'(ill));
        check({tag, "_latency"}, 64'(lat), 64'(exp_lat));
    endtask

    initial begin
        total_cnt = 0;
        pass_cnt  = 0;
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        alu_op    = 2'b00;
        funct7    = 7'd0;
        funct3    = 3'd0;
        op_a      = '0;
        op_b      = '0;

        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("rst_in_ready",  64'(in_ready),  64'd1);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_result",    64'(result),    64'd0);
        check("rst_operation", 64'(operation), 64'd0);
        check("rst_illegal",   64'(illegal),   64'd0);
        check("rst_busy",      64'(busy),      64'd0);

        // R-type SUB: 5 - 7
        issue(2'b10, 7'b0100000, 3'b000, 32'd5, 32'd7);
        expect_out("sub", 32'hFFFF_FFFE, 4'b0110, 1'b0, 1);
        retire();
        check("sub_retire_out_valid", 64'(out_valid), 64'd0);
        check("sub_retire_in_ready",  64'(in_ready),  64'd1);

        // Load/store ADD ignores funct fields
        issue(2'b00, 7'b0100000, 3'b000, 32'd5, 32'd7);
        expect_out("add", 32'd12, 4'b0010, 1'b0, 1);
        retire();

        // I-type SRA / SRL with shift amount taken from op_b[4:0]
        issue(2'b11, 7'b0100000, 3'b101, 32'h8000_0000, 32'h24);
        expect_out("sra", 32'hF800_0000, 4'b0101, 1'b0, 1);
        retire();
        issue(2'b11, 7'b0000000, 3'b101, 32'h8000_0000, 32'h24);
        expect_out("srl", 32'h0800_0000, 4'b0100, 1'b0, 1);
        retire();

        // SLT signed compare, SLTU unsigned compare, XOR, AND
        issue(2'b11, 7'b0000000, 3'b010, 32'hFFFF_FFFF, 32'd1);
        expect_out("slt", 32'd1, 4'b0111, 1'b0, 1);
        retire();
        issue(2'b10, 7'b0000000, 3'b011, 32'hFFFF_FFFF, 32'd1);
        expect_out("sltu", 32'd0, 4'b1000, 1'b0, 1);
        retire();
        issue(2'b10, 7'b0000000, 3'b100, 32'hF0F0_1234, 32'h0FF0_FFFF);
        expect_out("xor", 32'hFF00_EDCB, 4'b1100, 1'b0, 1);
        retire();
        issue(2'b10, 7'b0000000, 3'b111, 32'hF0F0_1234, 32'h0FF0_FFFF);
        expect_out("and", 32'h00F0_1234, 4'b0000, 1'b0, 1);
        retire();

        // MUL -1 * 3, then hold the result with out_ready low
        issue(2'b10, 7'b0000001, 3'b000, 32'hFFFF_FFFF, 32'd3);
        expect_out("mul", 32'hFFFF_FFFD, 4'b1001, 1'b0, 33);
        check("mul_busy_cycles", 64'(busy_cycles), 64'd32);
        alu_op   = 2'b00;
        funct7   = 7'd0;
        funct3   = 3'd0;
        op_a     = 32'd100;
        op_b     = 32'd200;
        in_valid = 1'b1;
        repeat (5) @(negedge clk);
        in_valid = 1'b0;
        check("mul_hold_result",    64'(result),    64'hFFFF_FFFD);
        check("mul_hold_operation", 64'(operation), 64'd9);
        check("mul_hold_out_valid", 64'(out_valid), 64'd1);
        check("mul_hold_in_ready",  64'(in_ready),  64'd0);
        retire();
        check("mul_retire_in_ready", 64'(in_ready), 64'd1);

        // Signed and unsigned division on the iterative path
        issue(2'b10, 7'b0000001, 3'b100, 32'hFFFF_FFF9, 32'd2);
        expect_out("div", 32'hFFFF_FFFD, 4'b1010, 1'b0, 33);
        retire();
        issue(2'b10, 7'b0000001, 3'b110, 32'hFFFF_FFF9, 32'd2);
        expect_out("rem", 32'hFFFF_FFFF, 4'b1101, 1'b0, 33);
        retire();
        issue(2'b10, 7'b0000001, 3'b111, 32'd100, 32'd7);
        expect_out("remu", 32'd2, 4'b1110, 1'b0, 33);
        retire();

        // Division special cases complete in one cycle
        issue(2'b10, 7'b0000001, 3'b101, 32'd1234, 32'd0);
        expect_out("divu_by0", 32'hFFFF_FFFF, 4'b1011, 1'b0, 1);
        retire();
        issue(2'b10, 7'b0000001, 3'b110, 32'd5, 32'd0);
        expect_out("rem_by0", 32'd5, 4'b1101, 1'b0, 1);
        retire();
        issue(2'b10, 7'b0000001, 3'b100, 32'h8000_0000, 32'hFFFF_FFFF);
        expect_out("div_ovf", 32'h8000_0000, 4'b1010, 1'b0, 1);
        retire();
        issue(2'b10, 7'b0000001, 3'b110, 32'h8000_0000, 32'hFFFF_FFFF);
        expect_out("rem_ovf", 32'd0, 4'b1101, 1'b0, 1);
        retire();

        // Unsupported M-extension encoding
        issue(2'b10, 7'b0000001, 3'b001, 32'd9, 32'd9);
        expect_out("illegal", 32'd0, 4'b1111, 1'b1, 1);
        retire();

        // Reset in the middle of a divide discards it
        @(negedge clk);
        alu_op   = 2'b10;
        funct7   = 7'b0000001;
        funct3   = 3'b100;
        op_a     = 32'd1000;
        op_b     = 32'd3;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (9) @(negedge clk);
        check("middiv_busy_before_rst", 64'(busy), 64'd1);
        rst = 1'b1;
        #1;
        check("middiv_rst_out_valid", 64'(out_valid), 64'd0);
        check("middiv_rst_busy",      64'(busy),      64'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("middiv_post_in_ready",  64'(in_ready),  64'd1);
        check("middiv_post_out_valid", 64'(out_valid), 64'd0);
        issue(2'b00, 7'd0, 3'b000, 32'd1, 32'd1);
        expect_out("post_rst_add", 32'd2, 4'b0010, 1'b0, 1);
        retire();

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
